// File: rtl/dmi_req_arbiter.sv
// dmi_req_arbiter
//   Round-robin arbiter that lets two debug front-ends (UART TAP, JTAG DTM)
//   share one DMI request/response path. Whole transactions are serialised:
//   one request is captured, issued downstream, its response (or a timeout
//   error) is returned to the owner, and only then is the next request taken.
//
// Ports
//   CLK_I, RST_I              clock, asynchronous active-high reset
//   REQ_VALID_I/REQ_READY_O   per-requester request handshake (bit i = requester i)
//   REQ_WRITE_I               per-requester write flag
//   REQ_ADDR0_I/REQ_ADDR1_I   request address per requester
//   REQ_DATA0_I/REQ_DATA1_I   request payload per requester
//   RSP_VALID_O/RSP_READY_I   per-requester response handshake
//   RSP_DATA_O, RSP_ERR_O     shared response payload and timeout flag
//   DMI_REQ_*                 downstream request channel (captured fields)
//   DMI_RSP_*                 downstream response channel
//   CLEAR_I                   synchronous abort back to idle, no response
module dmi_req_arbiter #(
  parameter int unsigned IRLENGTH = 5,
  parameter int unsigned WIDTH    = 41,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [1:0]          REQ_VALID_I,
  input  logic [1:0]          REQ_WRITE_I,
  input  logic [IRLENGTH-1:0] REQ_ADDR0_I,
  input  logic [IRLENGTH-1:0] REQ_ADDR1_I,
  input  logic [WIDTH-1:0]    REQ_DATA0_I,
  input  logic [WIDTH-1:0]    REQ_DATA1_I,
  output logic [1:0]          REQ_READY_O,
  output logic [1:0]          RSP_VALID_O,
  input  logic [1:0]          RSP_READY_I,
  output logic [WIDTH-1:0]    RSP_DATA_O,
  output logic                RSP_ERR_O,
  output logic                DMI_REQ_VALID_O,
  input  logic                DMI_REQ_READY_I,
  output logic                DMI_REQ_WRITE_O,
  output logic [IRLENGTH-1:0] DMI_REQ_ADDR_O,
  output logic [WIDTH-1:0]    DMI_REQ_DATA_O,
  input  logic                DMI_RSP_VALID_I,
  input  logic [WIDTH-1:0]    DMI_RSP_DATA_I,
  output logic                DMI_RSP_READY_O,
  input  logic                CLEAR_I
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

  // Captured request payload
  typedef struct packed {
    logic                write;
    logic [IRLENGTH-1:0] addr;
    logic [WIDTH-1:0]    data;
  } req_t;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic             dmi_req_valid_q, dmi_req_valid_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             winner;
  logic             accept;
  logic             expired;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       owner_onehot;

  // Winner: a lone requester wins; on a tie the one not granted last time wins
  always_comb begin
    winner = REQ_VALID_I[1];
    if (REQ_VALID_I == 2'b11) begin
      winner = ~last_grant_q;
    end
  end

  assign accept       = (state_q == ST_IDLE) && (|REQ_VALID_I) && !CLEAR_I;
  assign expired      = (cnt_q >= CNT_LAST);
  assign owner_onehot = owner_q ? 2'b10 : 2'b01;

  // Saturating increment so a stalled count can never wrap back below the limit
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State-decoded handshake outputs
  assign REQ_READY_O     = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign DMI_RSP_READY_O = (state_q == ST_IDLE) || (state_q == ST_WAIT);

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    req_d           = req_q;
    dmi_req_valid_d = dmi_req_valid_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;

    if (CLEAR_I) begin
      // Abort beats every other event; arbitration history is preserved
      state_d         = ST_IDLE;
      dmi_req_valid_d = 1'b0;
      rsp_valid_d     = 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_d         = winner;
            last_grant_d    = winner;
            cnt_d           = '0;
            req_d.write     = REQ_WRITE_I[winner];
            req_d.addr      = winner ? REQ_ADDR1_I : REQ_ADDR0_I;
            req_d.data      = winner ? REQ_DATA1_I : REQ_DATA0_I;
            dmi_req_valid_d = 1'b1;
            state_d         = ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          cnt_d = cnt_inc;
          if (DMI_REQ_READY_I) begin
            dmi_req_valid_d = 1'b0;
            state_d         = ST_WAIT;
          end else if (expired) begin
            dmi_req_valid_d = 1'b0;
            rsp_valid_d     = owner_onehot;
            rsp_data_d      = '0;
            rsp_err_d       = 1'b1;
            state_d         = ST_DONE;
          end
        end

        ST_WAIT: begin
          cnt_d = cnt_inc;
          if (DMI_RSP_VALID_I) begin
            rsp_valid_d = owner_onehot;
            rsp_data_d  = DMI_RSP_DATA_I;
            rsp_err_d   = 1'b0;
            state_d     = ST_DONE;
          end else if (expired) begin
            rsp_valid_d = owner_onehot;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_DONE;
          end
        end

        ST_DONE: begin
          if (RSP_READY_I[owner_q]) begin
            rsp_valid_d = 2'b00;
            state_d     = ST_IDLE;
          end
        end

        default: begin
          state_d         = ST_IDLE;
          dmi_req_valid_d = 1'b0;
          rsp_valid_d     = 2'b00;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= 1'b1;
      owner_q         <= 1'b0;
      cnt_q           <= '0;
      req_q           <= '0;
      dmi_req_valid_q <= 1'b0;
      rsp_valid_q     <= 2'b00;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      req_q           <= req_d;
      dmi_req_valid_q <= dmi_req_valid_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  assign DMI_REQ_VALID_O = dmi_req_valid_q;
  assign DMI_REQ_WRITE_O = req_q.write;
  assign DMI_REQ_ADDR_O  = req_q.addr;
  assign DMI_REQ_DATA_O  = req_q.data;
  assign RSP_VALID_O     = rsp_valid_q;
  assign RSP_DATA_O      = rsp_data_q;
  assign RSP_ERR_O       = rsp_err_q;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// tb_dmi_req_arbiter
//   Directed scenarios followed by a randomized run, all checked every cycle
//   against a transaction-level reference model of the arbiter.
module tb_dmi_req_arbiter;

  localparam int unsigned IRL = 5;
  localparam int unsigned W   = 41;
  localparam int          TO  = 8;

  localparam int P_IDLE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_WAIT  = 2;
  localparam int P_DONE  = 3;

  logic           CLK_I = 1'b0;
  logic           RST_I;
  logic [1:0]     REQ_VALID_I, REQ_WRITE_I, RSP_READY_I;
  logic [IRL-1:0] REQ_ADDR0_I, REQ_ADDR1_I;
  logic [W-1:0]   REQ_DATA0_I, REQ_DATA1_I;
  logic [1:0]     REQ_READY_O, RSP_VALID_O;
  logic [W-1:0]   RSP_DATA_O;
  logic           RSP_ERR_O;
  logic           DMI_REQ_VALID_O, DMI_REQ_READY_I, DMI_REQ_WRITE_O;
  logic [IRL-1:0] DMI_REQ_ADDR_O;
  logic [W-1:0]   DMI_REQ_DATA_O;
  logic           DMI_RSP_VALID_I;
  logic [W-1:0]   DMI_RSP_DATA_I;
  logic           DMI_RSP_READY_O;
  logic           CLEAR_I;

  always #5 CLK_I = ~CLK_I;

  dmi_req_arbiter #(.IRLENGTH(IRL), .WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .REQ_VALID_I(REQ_VALID_I), .REQ_WRITE_I(REQ_WRITE_I),
    .REQ_ADDR0_I(REQ_ADDR0_I), .REQ_ADDR1_I(REQ_ADDR1_I),
    .REQ_DATA0_I(REQ_DATA0_I), .REQ_DATA1_I(REQ_DATA1_I),
    .REQ_READY_O(REQ_READY_O), .RSP_VALID_O(RSP_VALID_O),
    .RSP_READY_I(RSP_READY_I), .RSP_DATA_O(RSP_DATA_O), .RSP_ERR_O(RSP_ERR_O),
    .DMI_REQ_VALID_O(DMI_REQ_VALID_O), .DMI_REQ_READY_I(DMI_REQ_READY_I),
    .DMI_REQ_WRITE_O(DMI_REQ_WRITE_O), .DMI_REQ_ADDR_O(DMI_REQ_ADDR_O),
    .DMI_REQ_DATA_O(DMI_REQ_DATA_O), .DMI_RSP_VALID_I(DMI_RSP_VALID_I),
    .DMI_RSP_DATA_I(DMI_RSP_DATA_I), .DMI_RSP_READY_O(DMI_RSP_READY_O),
    .CLEAR_I(CLEAR_I)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: current transaction phase plus captured fields
  int             m_ph;
  logic           m_last, m_owner, m_wr, m_err;
  logic [IRL-1:0] m_addr;
  logic [W-1:0]   m_data, m_rdata;
  int             m_t1;   // cycle index of the first issue cycle

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_last = 1'b1; m_owner = 1'b0; m_wr = 1'b0; m_err = 1'b0;
    m_addr = '0; m_data = '0; m_rdata = '0; m_t1 = 0;
  endtask

  function automatic logic [1:0] exp_req_ready();
    if (m_ph != P_IDLE || CLEAR_I || REQ_VALID_I == 2'b00) return 2'b00;
    if (REQ_VALID_I == 2'b11) return onehot(!m_last);
    return REQ_VALID_I;
  endfunction

  // Advance the model by one clock using the inputs held this cycle
  task automatic model_update();
    logic w;
    if (CLEAR_I) begin
      m_ph = P_IDLE;
      return;
    end
    case (m_ph)
      P_IDLE: if (REQ_VALID_I != 2'b00) begin
        w = (REQ_VALID_I == 2'b11) ? !m_last : REQ_VALID_I[1];
        m_owner = w; m_last = w;
        m_wr   = REQ_WRITE_I[w];
        m_addr = w ? REQ_ADDR1_I : REQ_ADDR0_I;
        m_data = w ? REQ_DATA1_I : REQ_DATA0_I;
        m_t1   = cyc + 1;
        m_ph   = P_ISSUE;
      end
      P_ISSUE: begin
        if (DMI_REQ_READY_I) m_ph = P_WAIT;
        else if (cyc - m_t1 >= TO - 1) begin m_ph = P_DONE; m_err = 1'b1; m_rdata = '0; end
      end
      P_WAIT: begin
        if (DMI_RSP_VALID_I) begin m_ph = P_DONE; m_err = 1'b0; m_rdata = DMI_RSP_DATA_I; end
        else if (cyc - m_t1 >= TO - 1) begin m_ph = P_DONE; m_err = 1'b1; m_rdata = '0; end
      end
      default: if (RSP_READY_I[m_owner]) m_ph = P_IDLE;
    endcase
  endtask

  task automatic check_comb();
    check("req_ready", 64'(REQ_READY_O), 64'(exp_req_ready()));
    check("dmi_rsp_ready", 64'(DMI_RSP_READY_O), 64'(m_ph == P_IDLE || m_ph == P_WAIT));
  endtask

  task automatic check_regs();
    check("dmi_req_valid", 64'(DMI_REQ_VALID_O), 64'(m_ph == P_ISSUE));
    check("rsp_valid", 64'(RSP_VALID_O), 64'((m_ph == P_DONE) ? onehot(m_owner) : 2'b00));
    check("rsp_data", 64'(RSP_DATA_O), 64'(m_rdata));
    check("rsp_err", 64'(RSP_ERR_O), 64'(m_err));
    check("dmi_write", 64'(DMI_REQ_WRITE_O), 64'(m_wr));
    check("dmi_addr", 64'(DMI_REQ_ADDR_O), 64'(m_addr));
    check("dmi_data", 64'(DMI_REQ_DATA_O), 64'(m_data));
  endtask

  // One clock: check combinational outputs, advance, check registered outputs
  task automatic step();
    #1;
    check_comb();
    model_update();
    @(posedge CLK_I);
    cyc++;
    #1;
    check_regs();
  endtask

  initial begin
    int n;
    logic [W-1:0] d_bp, d_hold;
    d_bp   = 41'h0AB_CDEF_0123;
    d_hold = 41'h155_AA55_3C3C;

    RST_I = 1'b1; CLEAR_I = 1'b0;
    REQ_VALID_I = 2'b00; REQ_WRITE_I = 2'b00; RSP_READY_I = 2'b00;
    REQ_ADDR0_I = '0; REQ_ADDR1_I = '0; REQ_DATA0_I = '0; REQ_DATA1_I = '0;
    DMI_REQ_READY_I = 1'b0; DMI_RSP_VALID_I = 1'b0; DMI_RSP_DATA_I = '0;
    model_reset();
    repeat (2) @(posedge CLK_I);
    #1;
    check_regs();
    check_comb();
    RST_I = 1'b0;

    // Tie fairness from reset: grants alternate 0,1,0,1
    REQ_VALID_I = 2'b11; REQ_WRITE_I = 2'b01;
    REQ_ADDR0_I = 5'h03; REQ_ADDR1_I = 5'h1C;
    REQ_DATA0_I = 41'h000_0000_0AAA; REQ_DATA1_I = 41'h000_0000_0BBB;
    DMI_REQ_READY_I = 1'b1; DMI_RSP_VALID_I = 1'b1; RSP_READY_I = 2'b11;
    DMI_RSP_DATA_I = 41'h0F0_0000_0001;
    for (int t = 0; t < 4; t++) begin
      #1;
      check("fair_grant", 64'(REQ_READY_O), 64'(onehot(t % 2 == 1)));
      repeat (4) step();
    end
    REQ_VALID_I = 2'b00; DMI_REQ_READY_I = 1'b0; DMI_RSP_VALID_I = 1'b0; RSP_READY_I = 2'b00;

    // Single read from requester 0
    REQ_VALID_I = 2'b01; REQ_WRITE_I = 2'b00; REQ_ADDR0_I = 5'h11;
    step();
    check("rd_addr_t1", 64'(DMI_REQ_ADDR_O), 64'h11);
    check("rd_valid_t1", 64'(DMI_REQ_VALID_O), 64'h1);
    REQ_VALID_I = 2'b00; DMI_REQ_READY_I = 1'b1;
    step();
    DMI_REQ_READY_I = 1'b0; DMI_RSP_VALID_I = 1'b1; DMI_RSP_DATA_I = 41'h1_2345_6789;
    step();
    check("rd_rsp_valid_t3", 64'(RSP_VALID_O), 64'h1);
    check("rd_rsp_data_t3", 64'(RSP_DATA_O), 64'h1_2345_6789);
    check("rd_rsp_err_t3", 64'(RSP_ERR_O), 64'h0);
    DMI_RSP_VALID_I = 1'b0; RSP_READY_I = 2'b01;
    step();
    RSP_READY_I = 2'b00;

    // Timeout: requester 1 write, DMI accepts but never answers
    REQ_VALID_I = 2'b10; REQ_WRITE_I = 2'b10; REQ_ADDR1_I = 5'h07;
    REQ_DATA1_I = 41'h1FF_FFFF_FFFF;
    step();
    REQ_VALID_I = 2'b00; DMI_REQ_READY_I = 1'b1;
    n = 0;
    while (RSP_VALID_O == 2'b00 && n < 20) begin
      step();
      DMI_REQ_READY_I = 1'b0;
      n++;
    end
    check("to_latency", 64'(n), 64'(TO));
    check("to_rsp_valid", 64'(RSP_VALID_O), 64'h2);
    check("to_err", 64'(RSP_ERR_O), 64'h1);
    check("to_data", 64'(RSP_DATA_O), 64'h0);
    RSP_READY_I = 2'b10;
    step();
    RSP_READY_I = 2'b00; DMI_RSP_VALID_I = 1'b1; DMI_RSP_DATA_I = 41'h0DE_AD00_BEEF;
    repeat (2) step();
    check("late_rsp_dropped", 64'(RSP_VALID_O), 64'h0);
    DMI_RSP_VALID_I = 1'b0;

    // Downstream backpressure: fields held while DMI is not ready
    REQ_VALID_I = 2'b01; REQ_WRITE_I = 2'b01; REQ_ADDR0_I = 5'h0A; REQ_DATA0_I = d_bp;
    step();
    REQ_VALID_I = 2'b00; REQ_DATA0_I = W'({$urandom, $urandom}); REQ_ADDR0_I = 5'h15;
    for (int k = 0; k < 6; k++) begin
      check("bp_valid", 64'(DMI_REQ_VALID_O), 64'h1);
      check("bp_addr", 64'(DMI_REQ_ADDR_O), 64'h0A);
      check("bp_data", 64'(DMI_REQ_DATA_O), 64'(d_bp));
      check("bp_write", 64'(DMI_REQ_WRITE_O), 64'h1);
      DMI_REQ_READY_I = (k == 5);
      step();
    end
    check("bp_valid_drop", 64'(DMI_REQ_VALID_O), 64'h0);
    DMI_REQ_READY_I = 1'b0; DMI_RSP_VALID_I = 1'b1; DMI_RSP_DATA_I = 41'h000_0000_0042;
    step();
    check("bp_done", 64'(RSP_VALID_O), 64'h1);
    DMI_RSP_VALID_I = 1'b0; RSP_READY_I = 2'b01;
    step();
    RSP_READY_I = 2'b00;

    // Response hold by requester 1 while requester 0 is waiting
    REQ_VALID_I = 2'b10; REQ_WRITE_I = 2'b00; REQ_ADDR1_I = 5'h1F;
    step();
    REQ_VALID_I = 2'b00; DMI_REQ_READY_I = 1'b1;
    step();
    DMI_REQ_READY_I = 1'b0; DMI_RSP_VALID_I = 1'b1; DMI_RSP_DATA_I = d_hold;
    step();
    DMI_RSP_VALID_I = 1'b0; DMI_RSP_DATA_I = '0;
    REQ_VALID_I = 2'b01; RSP_READY_I = 2'b01;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("hold_rsp_valid", 64'(RSP_VALID_O), 64'h2);
      check("hold_rsp_data", 64'(RSP_DATA_O), 64'(d_hold));
      check("hold_req_ready", 64'(REQ_READY_O), 64'h0);
      step();
    end
    RSP_READY_I = 2'b10;
    step();
    RSP_READY_I = 2'b00;
    #1;
    check("hold_next_grant", 64'(REQ_READY_O), 64'h1);
    step();

    // Clear in WAIT: back to idle, no response, no grant while clear is high
    REQ_VALID_I = 2'b00; DMI_REQ_READY_I = 1'b1;
    step();
    DMI_REQ_READY_I = 1'b0; CLEAR_I = 1'b1; DMI_RSP_VALID_I = 1'b1;
    step();
    check("clr_no_rsp", 64'(RSP_VALID_O), 64'h0);
    check("clr_no_issue", 64'(DMI_REQ_VALID_O), 64'h0);
    DMI_RSP_VALID_I = 1'b0; REQ_VALID_I = 2'b01;
    #1;
    check("clr_ready_blocked", 64'(REQ_READY_O), 64'h0);
    step();
    CLEAR_I = 1'b0;
    #1;
    check("clr_ready_after", 64'(REQ_READY_O), 64'h1);
    step();

    // Asynchronous reset while issuing
    check("rst_pre_issue", 64'(DMI_REQ_VALID_O), 64'h1);
    RST_I = 1'b1;
    #1;
    check("rst_async_valid", 64'(DMI_REQ_VALID_O), 64'h0);
    model_reset();
    check_regs();
    REQ_VALID_I = 2'b00;
    #1;
    RST_I = 1'b0;
    DMI_RSP_VALID_I = 1'b1; DMI_RSP_DATA_I = 41'h0CC_CCCC_CCCC;
    repeat (2) step();
    check("rst_late_dropped", 64'(RSP_VALID_O), 64'h0);
    DMI_RSP_VALID_I = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      REQ_VALID_I     = 2'($urandom);
      REQ_WRITE_I     = 2'($urandom);
      REQ_ADDR0_I     = IRL'($urandom);
      REQ_ADDR1_I     = IRL'($urandom);
      REQ_DATA0_I     = W'({$urandom, $urandom});
      REQ_DATA1_I     = W'({$urandom, $urandom});
      DMI_REQ_READY_I = ($urandom % 3) == 0;
      DMI_RSP_VALID_I = ($urandom % 4) == 0;
      DMI_RSP_DATA_I  = W'({$urandom, $urandom});
      RSP_READY_I     = 2'($urandom);
      CLEAR_I         = ($urandom % 40) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
